regfile_wb_queue: RTL and testbench

Write-side companion to the 8×19-bit register file. It owns the register file's single write port. Core writebacks pass straight through with priority. Late writebacks from multi-cycle units are buffered in a small in-order queue and drained into the port on idle cycles. It also forwards pending queued values to the read side, so operands are never stale.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/wb_match.sv | 32 +++
 rtl/regfile_wb_queue.sv | 129 ++++++++++++
 tb/tb_regfile_wb_queue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the 8x19 register file write side: request and queue-slot layouts.
package regfile_pkg;
  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 19;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    wb_req_t req;
    logic    live;
  } wb_slot_t;
endpackage

// File: rtl/wb_match.sv
// Youngest live pending value for one read address; purely combinational, no flow control.
module wb_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_slot_t [DEPTH-1:0]      slots,
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic [$clog2(DEPTH):0]    count,
  input  logic [ADDR_W-1:0]         addr,
  output logic                      hit,
  output logic [DATA_W-1:0]         data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int off = 0; off < DEPTH; off++) begin
      idx = head + PW'(off);
      if ((PW+1)'(off) < count && slots[idx].live &&
          slots[idx].req.addr == addr && addr != '0) begin
        hit  = 1'b1;
        data = slots[idx].req.data;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-port owner: core writebacks win, late writebacks queue in order and drain on idle cycles.
// rf_* and fwd_* are combinational; pushes stall only when full or flushing, pending values forward next cycle.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 19,
  parameter int ADDR_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  input  logic                       core_wb_en,
  input  logic [ADDR_W-1:0]          core_wb_addr,
  input  logic [DATA_W-1:0]          core_wb_data,
  output logic                       rf_w_enable,
  output logic [ADDR_W-1:0]          rf_add3,
  output logic [DATA_W-1:0]          rf_data_in,
  input  logic [ADDR_W-1:0]          fwd_add1,
  input  logic [ADDR_W-1:0]          fwd_add2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  import regfile_pkg::*;

  localparam int PW = $clog2(DEPTH);

  wb_slot_t [DEPTH-1:0] slot_q, slot_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [PW:0]          count_q, count_d;

  wb_slot_t      head_slot;
  logic          head_occ, pop, push, push_store;
  logic [PW-1:0] off;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full && !flush;
  assign count    = count_q;

  always_comb begin
    head_slot  = slot_q[head_q];
    head_occ   = !empty;
    // A dead head frees its slot even while the core owns the port.
    pop        = head_occ && (!head_slot.live || !core_wb_en);
    push       = in_valid && in_ready;
    push_store = push && (in_addr != '0);

    rf_w_enable = 1'b0;
    rf_add3     = '0;
    rf_data_in  = '0;
    if (core_wb_en) begin
      rf_w_enable = 1'b1;
      rf_add3     = core_wb_addr;
      rf_data_in  = core_wb_data;
    end else if (head_occ && head_slot.live) begin
      rf_w_enable = 1'b1;
      rf_add3     = head_slot.req.addr;
      rf_data_in  = head_slot.req.data;
    end

    slot_d  = slot_q;
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push_store);
    count_d = count_q + (PW+1)'(push_store) - (PW+1)'(pop);
    off     = '0;

    // The core value is newer than anything already queued for the same register.
    if (core_wb_en && core_wb_addr != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - head_q;
        if ({1'b0, off} < count_q && slot_q[i].req.addr == core_wb_addr)
          slot_d[i].live = 1'b0;
      end
    end

    if (push_store) begin
      slot_d[tail_q].req.addr = in_addr;
      slot_d[tail_q].req.data = in_data;
      slot_d[tail_q].live     = 1'b1;
    end

    if (flush) begin
      slot_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .slots (slot_q),
    .head  (head_q),
    .count (count_q),
    .addr  (fwd_add1),
    .hit   (fwd_hit1),
    .data  (fwd_data1)
  );

  wb_match #(.DEPTH(DEPTH)) u_match2 (
    .slots (slot_q),
    .head  (head_q),
    .count (count_q),
    .addr  (fwd_add2),
    .hit   (fwd_hit2),
    .data  (fwd_data2)
  );
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a queue-based reference model checked every cycle.
module tb_regfile_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              core_wb_en;
  logic [ADDR_W-1:0] core_wb_addr;
  logic [DATA_W-1:0] core_wb_data;
  logic              rf_w_enable;
  logic [ADDR_W-1:0] rf_add3;
  logic [DATA_W-1:0] rf_data_in;
  logic [ADDR_W-1:0] fwd_add1, fwd_add2;
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
  logic [2:0]        count;
  logic              empty, full;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .flush        (flush),
    .core_wb_en   (core_wb_en),
    .core_wb_addr (core_wb_addr),
    .core_wb_data (core_wb_data),
    .rf_w_enable  (rf_w_enable),
    .rf_add3      (rf_add3),
    .rf_data_in   (rf_data_in),
    .fwd_add1     (fwd_add1),
    .fwd_add2     (fwd_add2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                live;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_fwd(input logic [ADDR_W-1:0] a, output bit h,
                                    output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].live && mq[i].addr == a) begin
          h = 1'b1;
          d = mq[i].data;
          break;
        end
      end
    end
  endfunction

  // Reference: a plain in-order list; outputs checked, then advanced with the inputs held across the edge.
  always @(negedge clk) begin : cmp
    bit                exp_rdy, exp_we, do_pop, h;
    logic [ADDR_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_d, d;
    ent_t              e;
    if (reset) mq.delete();
    exp_rdy = (mq.size() < DEPTH) && !flush;
    check("m_count", count, mq.size());
    check("m_empty", empty, mq.size() == 0);
    check("m_full", full, mq.size() == DEPTH);
    check("m_in_ready", in_ready, exp_rdy);
    exp_we = 1'b0;
    exp_a  = '0;
    exp_d  = '0;
    if (core_wb_en) begin
      exp_we = 1'b1;
      exp_a  = core_wb_addr;
      exp_d  = core_wb_data;
    end else if (mq.size() > 0 && mq[0].live) begin
      exp_we = 1'b1;
      exp_a  = mq[0].addr;
      exp_d  = mq[0].data;
    end
    check("m_rf_w_enable", rf_w_enable, exp_we);
    if (exp_we) begin
      check("m_rf_add3", rf_add3, exp_a);
      check("m_rf_data_in", rf_data_in, exp_d);
    end
    model_fwd(fwd_add1, h, d);
    check("m_fwd_hit1", fwd_hit1, h);
    check("m_fwd_data1", fwd_data1, d);
    model_fwd(fwd_add2, h, d);
    check("m_fwd_hit2", fwd_hit2, h);
    check("m_fwd_data2", fwd_data2, d);
    if (!reset) begin
      if (flush) begin
        mq.delete();
      end else begin
        do_pop = (mq.size() > 0) && (!mq[0].live || !core_wb_en);
        if (core_wb_en && core_wb_addr != 0)
          foreach (mq[i]) if (mq[i].addr == core_wb_addr) mq[i].live = 1'b0;
        if (do_pop) void'(mq.pop_front());
        if (in_valid && exp_rdy && in_addr != 0) begin
          e.addr = in_addr;
          e.data = in_data;
          e.live = 1'b1;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic core_set(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    core_wb_en   = en;
    core_wb_addr = a;
    core_wb_data = d;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_addr = '0; in_data = '0; flush = 1'b0;
    core_set(1'b0, 3'd0, 19'h0);
    fwd_add1 = 3'd2; fwd_add2 = 3'd0;
    @(negedge clk);
    check("reset_count", count, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_fwd_hit1", fwd_hit1, 0);
    check("reset_fwd_data1", fwd_data1, 0);
    check("reset_rf_w_enable", rf_w_enable, 0);
    tick();
    reset = 1'b0;

    // Reset mid-operation: three entries held by a busy core, then dropped.
    core_set(1'b1, 3'd7, 19'h00AAA);
    push_set(3'd1, 19'h00001); tick();
    push_set(3'd2, 19'h00002); tick();
    push_set(3'd3, 19'h00003); tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_pre_count", count, 3);
    check("midrst_pre_hit", fwd_hit1, 1);
    check("midrst_pre_data", fwd_data1, 19'h00002);
    #2 reset = 1'b1;
    core_wb_en = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_fwd_hit1", fwd_hit1, 0);
    check("midrst_rf_w_enable", rf_w_enable, 0);
    tick(); tick();
    reset = 1'b0;

    // Address zero is accepted but never stored.
    push_set(3'd0, 19'h7FFFF);
    fwd_add1 = 3'd0;
    @(negedge clk);
    check("a0_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("a0_count", count, 0);
    check("a0_rf_w_enable", rf_w_enable, 0);
    check("a0_fwd_hit1", fwd_hit1, 0);
    tick();

    // Fill behind a busy core, refuse a fifth, then drain in order.
    core_set(1'b1, 3'd7, 19'h00AAA);
    for (int i = 1; i <= 4; i++) begin
      push_set(ADDR_W'(i), DATA_W'(32'h100 + i));
      tick();
    end
    push_set(3'd5, 19'h00055);
    @(negedge clk);
    check("full_full", full, 1);
    check("full_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    core_wb_en = 1'b0;
    fwd_add1 = 3'd5;
    @(negedge clk);
    check("full_count", count, 4);
    check("full_fifth_dropped", fwd_hit1, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        tick();
        @(negedge clk);
      end
      check("drain_we", rf_w_enable, 1);
      check("drain_add3", rf_add3, i);
      check("drain_data", rf_data_in, 32'h100 + i);
    end
    tick();
    @(negedge clk);
    check("drain_empty", empty, 1);
    check("drain_idle_we", rf_w_enable, 0);

    // Youngest of two pending writes to the same register forwards.
    core_set(1'b1, 3'd7, 19'h00AAA);
    push_set(3'd5, 19'h00011); tick();
    push_set(3'd5, 19'h7FFFF); tick();
    in_valid = 1'b0;
    fwd_add2 = 3'd5;
    @(negedge clk);
    check("young_hit2", fwd_hit2, 1);
    check("young_data2", fwd_data2, 19'h7FFFF);
    core_wb_en = 1'b0;
    tick(); tick(); tick();
    fwd_add2 = 3'd0;

    // Core write to a pending register kills the queued value.
    core_set(1'b1, 3'd7, 19'h00AAA);
    push_set(3'd3, 19'h00123); tick();
    in_valid = 1'b0;
    core_set(1'b1, 3'd3, 19'h00456);
    fwd_add1 = 3'd3;
    @(negedge clk);
    check("ovr_still_hit", fwd_hit1, 1);
    check("ovr_core_add3", rf_add3, 3);
    check("ovr_core_data", rf_data_in, 19'h00456);
    tick();
    core_wb_en = 1'b0;
    @(negedge clk);
    check("ovr_hit_gone", fwd_hit1, 0);
    check("ovr_dead_count", count, 1);
    check("ovr_dead_no_write", rf_w_enable, 0);
    tick();
    @(negedge clk);
    check("ovr_popped", count, 0);

    // Steady push+pop at count 2 across a pointer wrap.
    core_set(1'b1, 3'd7, 19'h00AAA);
    push_set(3'd2, 19'h00201); tick();
    push_set(3'd3, 19'h00202); tick();
    core_wb_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push_set(ADDR_W'(((3 + k) % 7) + 1), DATA_W'(32'h203 + k));
      @(negedge clk);
      check("pp_count", count, 2);
      check("pp_data", rf_data_in, 32'h201 + k);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pp_tail1", rf_data_in, 19'h00207);
    tick();
    @(negedge clk);
    check("pp_tail2", rf_data_in, 19'h00208);
    tick();
    @(negedge clk);
    check("pp_empty", empty, 1);

    // Flush blocks the push and clears the queue.
    core_set(1'b1, 3'd7, 19'h00AAA);
    push_set(3'd4, 19'h00044); tick();
    push_set(3'd6, 19'h00066);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("flush_pre_count", count, 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    core_wb_en = 1'b0;
    @(negedge clk);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_no_write", rf_w_enable, 0);
    tick();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
